// File: rtl/ram_responder.sv
// ram_responder
//   Single-port 32-bit word memory answering the RAM side of the data cache.
//   Requests run through a FREE/BUSY/ACCESS/ERROR handshake with LAT wait
//   states in BUSY before the one-cycle ACCESS.
//
// Parameters
//   LAT    : wait-state cycles spent in BUSY before ACCESS (0..15)
//   ADDR_W : word-index width, DEPTH = 2**ADDR_W words
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   asynchronous active-high reset (clears memory too)
//   ramREN   in   read request, held until ACCESS
//   ramWEN   in   write request, held until ACCESS
//   ramaddr  in   byte address, word aligned, must fit in DEPTH words
//   ramstore in   write data, sampled on the edge entering ACCESS
//   ramload  out  read data, registered, updated only when a read enters ACCESS
//   ramstate out  FREE=0, BUSY=1, ACCESS=2, ERROR=3, registered
module ram_responder #(
    parameter int unsigned LAT    = 2,
    parameter int unsigned ADDR_W = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);

    localparam int unsigned DEPTH    = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } state_e;

    state_e      st_q, st_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] la_q, la_d;
    logic        lop_q, lop_d;     // 1 = write, 0 = read
    logic [31:0] ramload_q;
    logic [31:0] mem_q [DEPTH];

    logic              req;
    logic              addr_ok;
    logic              enter_access;
    logic [ADDR_W-1:0] idx_d;

    assign req     = ramREN ^ ramWEN;
    assign addr_ok = (ramaddr[1:0] == 2'b00) && (ramaddr[31:ADDR_W+2] == '0);

    // The full byte address is latched so that any change while BUSY,
    // including one into an invalid address, is seen as an abort.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        la_d  = la_q;
        lop_d = lop_q;
        case (st_q)
            FREE: begin
                if ((ramREN && ramWEN) || (req && !addr_ok)) begin
                    st_d = ERROR;
                end else if (req) begin
                    la_d  = ramaddr;
                    lop_d = ramWEN;
                    if (LAT == 0) begin
                        st_d = ACCESS;
                    end else begin
                        st_d  = BUSY;
                        cnt_d = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (!req || (ramaddr != la_q) || (ramWEN != lop_q)) begin
                    st_d = FREE;
                end else if (cnt_q == 4'd0) begin
                    st_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: st_d = FREE;
            ERROR: begin
                if (!ramREN && !ramWEN) begin
                    st_d = FREE;
                end
            end
            default: st_d = FREE;
        endcase
    end

    // ACCESS always returns to FREE, so any ACCESS next-state is an entry.
    // The _d copies are used so the LAT=0 path acts on the address latched
    // on this same edge.
    assign enter_access = (st_d == ACCESS);
    assign idx_d        = la_d[ADDR_W+1:2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q      <= FREE;
            cnt_q     <= '0;
            la_q      <= '0;
            lop_q     <= 1'b0;
            ramload_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            la_q  <= la_d;
            lop_q <= lop_d;
            if (enter_access) begin
                if (lop_d) begin
                    mem_q[idx_d] <= ramstore;
                end else begin
                    ramload_q <= mem_q[idx_d];
                end
            end
        end
    end

    assign ramload  = ramload_q;
    assign ramstate = st_q;

endmodule
